// File: rtl/vec_player_pkg.sv
// Shared types and helpers for the vector player: FSM states, playback mode
// encodings and the playback length clamp.
package vec_player_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_LOOP    = 2'b01;
  localparam logic [1:0] MODE_STEP    = 2'b10;

  // Requested length limited to the number of entries from the first played index.
  function automatic int unsigned clamp_len(input int unsigned req, input int unsigned max_len);
    return (req < max_len) ? req : max_len;
  endfunction

endpackage

// File: rtl/vec_player_mem.sv
// Vector memory: DEPTH words of {obs, payload}, synchronous write port and a
// registered read port so it can be replaced by a block RAM macro.
module vec_player_mem #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 41,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W:0]   wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W:0]   rd_data
);

  logic [DATA_W:0] mem [DEPTH];

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/vec_player.sv
// Stimulus sequencer: plays stored {obs, payload} words in order under
// one-shot, loop or single-step control with start/halt/done handshakes.
module vec_player
  import vec_player_pkg::*;
#(
  parameter int DATA_W    = 128,
  parameter int DEPTH     = 41,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int FIRST_IDX = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W:0]   load_data,
  input  logic [ADDR_W-1:0] len,
  input  logic [1:0]        mode,
  input  logic              start,
  input  logic              step,
  input  logic              halt,
  output logic [DATA_W-1:0] out_data,
  output logic              out_obs,
  output logic              out_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done
);

  localparam int unsigned       MAX_LEN   = DEPTH - FIRST_IDX;
  localparam logic [ADDR_W-1:0] FIRST_PTR = ADDR_W'(FIRST_IDX);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] rd_ptr, last, eff_len, nxt_ptr, rd_addr;
  logic [1:0]        mode_r, start_mode;
  logic              idle_like, start_go, emit, at_last, wr_en, rd_en;
  logic [DATA_W:0]   rd_word;

  assign eff_len   = ADDR_W'(clamp_len(32'(len), MAX_LEN));
  assign idle_like = (state == IDLE) || (state == DONE);
  assign start_go  = idle_like && start && !halt;
  assign emit      = !halt && ((state == RUN) || ((state == STEP) && step));
  assign at_last   = (rd_ptr == last);
  assign nxt_ptr   = at_last ? FIRST_PTR : rd_ptr + ONE;
  assign wr_en     = load_en && idle_like && (32'(load_addr) < DEPTH);

  // The read port runs one entry ahead of the output register: the first
  // entry is fetched on the start edge, each emission fetches its successor.
  // A write landing on that start edge is therefore not seen by the first entry.
  assign rd_en   = start_go || emit;
  assign rd_addr = start_go ? FIRST_PTR : nxt_ptr;

  // Reserved mode 11 collapses to one-shot when latched.
  assign start_mode = (mode == MODE_STEP) ? MODE_STEP :
                      (mode == MODE_LOOP) ? MODE_LOOP : MODE_ONESHOT;

  vec_player_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_addr(load_addr),
    .wr_data(load_data),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (halt) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (eff_len == '0)                  state_nxt = DONE;
            else if (start_mode == MODE_STEP)   state_nxt = STEP;
            else                                state_nxt = RUN;
          end
        end
        RUN:     if (at_last && (mode_r == MODE_ONESHOT)) state_nxt = DONE;
        STEP:    if (step && at_last) state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Length, mode and pointer are captured on start and frozen for the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      last   <= '0;
      mode_r <= MODE_ONESHOT;
    end else if (start_go) begin
      rd_ptr <= FIRST_PTR;
      last   <= FIRST_PTR + eff_len - ONE;
      mode_r <= start_mode;
    end else if (emit) begin
      rd_ptr <= nxt_ptr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_obs   <= 1'b0;
      pc        <= '0;
    end else begin
      out_valid <= emit;
      if (emit) begin
        out_data <= rd_word[DATA_W-1:0];
        out_obs  <= rd_word[DATA_W];
        pc       <= rd_ptr;
      end
    end
  end

  assign busy = (state == RUN) || (state == STEP);
  assign done = (state == DONE);

endmodule

// File: tb/tb_vec_player.sv
// Self-checking bench for vec_player: directed vectors with literal
// expectations plus a play-list model compared on every cycle.
module tb_vec_player;

  localparam int DATA_W = 128;
  localparam int DEPTH  = 41;
  localparam int FIRST  = 1;
  localparam int MAXN   = DEPTH - FIRST;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load_en = 1'b0;
  logic [5:0]        load_addr = '0;
  logic [DATA_W:0]   load_data = '0;
  logic [5:0]        len = '0;
  logic [1:0]        mode = '0;
  logic              start = 1'b0;
  logic              step = 1'b0;
  logic              halt = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_obs;
  logic              out_valid;
  logic [5:0]        pc;
  logic              busy;
  logic              done;

  int checks = 0;
  int failures = 0;
  int validSeen = 0;

  vec_player #(
    .DATA_W(DATA_W),
    .DEPTH(DEPTH),
    .FIRST_IDX(FIRST)
  ) dut (
    .clk(clk), .rst(rst),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .len(len), .mode(mode), .start(start), .step(step), .halt(halt),
    .out_data(out_data), .out_obs(out_obs), .out_valid(out_valid),
    .pc(pc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Model: tracks playback as "k entries emitted out of a list of m_len".
  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_DONE = 3;
  logic [DATA_W:0]   m_mem [DEPTH];
  logic [DATA_W:0]   m_first, word;
  int                m_phase, old_phase, m_len, m_k, idx;
  logic              m_loop;
  logic              exp_valid, exp_obs;
  logic [DATA_W-1:0] exp_data;
  logic [5:0]        exp_pc;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = M_IDLE;
      exp_valid = 1'b0;
      exp_data = '0;
      exp_obs = 1'b0;
      exp_pc = '0;
    end else begin
      old_phase = m_phase;
      if (halt) begin
        m_phase = M_IDLE;
        exp_valid = 1'b0;
      end else if (m_phase == M_IDLE || m_phase == M_DONE) begin
        exp_valid = 1'b0;
        if (start) begin
          m_len = (int'(len) > MAXN) ? MAXN : int'(len);
          m_k = 0;
          m_loop = (mode == 2'b01);
          m_first = m_mem[FIRST];
          m_phase = (m_len == 0) ? M_DONE : ((mode == 2'b10) ? M_STEP : M_RUN);
        end
      end else if (m_phase == M_RUN || step) begin
        idx = FIRST + (m_k % m_len);
        word = (m_k == 0) ? m_first : m_mem[idx];
        exp_data = word[DATA_W-1:0];
        exp_obs = word[DATA_W];
        exp_pc = 6'(idx);
        exp_valid = 1'b1;
        m_k++;
        if (!m_loop && m_k == m_len) m_phase = M_DONE;
      end else begin
        exp_valid = 1'b0;
      end
      if (load_en && (old_phase == M_IDLE || old_phase == M_DONE) && int'(load_addr) < DEPTH)
        m_mem[load_addr] = load_data;
    end
  end

  task automatic checkOutput(input string name, input logic [DATA_W:0] actual,
                             input logic [DATA_W:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("cmp_valid", out_valid, exp_valid);
      checkOutput("cmp_data", out_data, exp_data);
      checkOutput("cmp_obs", out_obs, exp_obs);
      checkOutput("cmp_pc", pc, exp_pc);
      checkOutput("cmp_busy", busy, m_phase == M_RUN || m_phase == M_STEP);
      checkOutput("cmp_done", done, m_phase == M_DONE);
      if (out_valid) validSeen++;
    end
  end

  task automatic applyStimulus(input logic s_start, input logic s_step, input logic s_halt,
                               input logic [1:0] s_mode, input logic [5:0] s_len,
                               input logic s_load, input logic [5:0] s_addr,
                               input logic [DATA_W:0] s_data);
    @(negedge clk);
    start = s_start; step = s_step; halt = s_halt; mode = s_mode; len = s_len;
    load_en = s_load; load_addr = s_addr; load_data = s_data;
  endtask

  task automatic quiet();
    applyStimulus(0, 0, 0, 2'b00, 6'd0, 0, 6'd0, '0);
  endtask

  task automatic loadWord(input logic [5:0] a, input logic [DATA_W:0] d);
    applyStimulus(0, 0, 0, 2'b00, 6'd0, 1, a, d);
  endtask

  task automatic waitDone(input string name, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, done, 1);
  endtask

  initial begin
    $display("[TB] start");
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_valid", out_valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_pc", pc, 0);

    // one-shot, len 3
    loadWord(6'd1, {1'b0, 128'h1});
    loadWord(6'd2, {1'b1, 128'h2});
    loadWord(6'd3, {1'b0, 128'h3});
    applyStimulus(1, 0, 0, 2'b00, 6'd3, 0, 6'd0, '0);
    quiet();
    checkOutput("os_busy", busy, 1);
    checkOutput("os_novalid_yet", out_valid, 0);
    @(negedge clk);
    checkOutput("os_v1", {out_valid, out_obs, pc}, {1'b1, 1'b0, 6'd1});
    checkOutput("os_d1", out_data, 128'h1);
    @(negedge clk);
    checkOutput("os_v2", {out_valid, out_obs, pc}, {1'b1, 1'b1, 6'd2});
    checkOutput("os_d2", out_data, 128'h2);
    @(negedge clk);
    checkOutput("os_v3", {out_valid, out_obs, pc, done}, {1'b1, 1'b0, 6'd3, 1'b1});
    @(negedge clk);
    checkOutput("os_end", {out_valid, done, pc}, {1'b0, 1'b1, 6'd3});
    checkOutput("os_hold", out_data, 128'h3);

    // loop, len 2
    loadWord(6'd1, {1'b0, 128'hA});
    loadWord(6'd2, {1'b1, 128'hB});
    applyStimulus(1, 0, 0, 2'b01, 6'd2, 0, 6'd0, '0);
    quiet();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("loop_data", out_data, (i % 2 == 0) ? 129'hA : 129'hB);
      checkOutput("loop_flags", {out_valid, busy, done}, 3'b110);
    end
    applyStimulus(0, 0, 1, 2'b00, 6'd0, 0, 6'd0, '0);
    quiet();
    checkOutput("loop_halt", {out_valid, busy, done}, 3'b000);

    // single step, len 3
    applyStimulus(1, 0, 0, 2'b10, 6'd3, 0, 6'd0, '0);
    validSeen = 0;
    quiet();
    for (int s = 0; s < 3; s++) begin
      repeat (4) @(negedge clk);
      applyStimulus(0, 1, 0, 2'b00, 6'd0, 0, 6'd0, '0);
      quiet();
    end
    repeat (2) @(negedge clk);
    checkOutput("step_count", validSeen, 3);
    checkOutput("step_done", done, 1);

    // len 0 from IDLE
    applyStimulus(0, 0, 1, 2'b00, 6'd0, 0, 6'd0, '0);
    quiet();
    checkOutput("len0_pre", done, 0);
    applyStimulus(1, 0, 0, 2'b00, 6'd0, 0, 6'd0, '0);
    quiet();
    checkOutput("len0_done", {done, out_valid, busy}, 3'b100);

    // len 60 clamps to 40; load during RUN ignored
    for (int i = 1; i <= 40; i++) loadWord(6'(i), {i[0], 128'(i * 3 + 7)});
    applyStimulus(1, 0, 0, 2'b00, 6'd60, 0, 6'd0, '0);
    validSeen = 0;
    quiet();
    applyStimulus(0, 0, 0, 2'b00, 6'd0, 1, 6'd5, 129'hDEAD);
    quiet();
    waitDone("len60_timeout", 60);
    @(negedge clk);
    checkOutput("len60_count", validSeen, 40);
    checkOutput("len60_pc", pc, 40);
    checkOutput("len60_data", out_data, 127);
    applyStimulus(1, 0, 0, 2'b00, 6'd5, 0, 6'd0, '0);
    quiet();
    waitDone("replay_timeout", 20);
    checkOutput("run_load_ignored", out_data, 22);

    // halt with start in IDLE
    applyStimulus(0, 0, 1, 2'b00, 6'd0, 0, 6'd0, '0);
    applyStimulus(1, 0, 1, 2'b00, 6'd3, 0, 6'd0, '0);
    quiet();
    checkOutput("halt_start", {busy, done, out_valid}, 3'b000);

    // halt on last one-shot entry
    applyStimulus(1, 0, 0, 2'b00, 6'd3, 0, 6'd0, '0);
    quiet();
    @(negedge clk);
    applyStimulus(0, 0, 1, 2'b00, 6'd0, 0, 6'd0, '0);
    quiet();
    checkOutput("halt_last", {busy, done, out_valid, pc}, {3'b000, 6'd2});
    checkOutput("halt_last_data", out_data, 13);

    // start and load to the first entry on the same edge
    loadWord(6'd1, 129'h111);
    applyStimulus(1, 0, 0, 2'b00, 6'd1, 1, 6'd1, 129'h222);
    quiet();
    @(negedge clk);
    checkOutput("collide_old", {out_valid, out_data}, {1'b1, 128'h111});
    applyStimulus(1, 0, 0, 2'b00, 6'd1, 0, 6'd0, '0);
    quiet();
    @(negedge clk);
    checkOutput("collide_new", out_data, 129'h222);

    // reset in the second valid cycle
    for (int i = 1; i <= 4; i++) loadWord(6'(i), 129'(16 + i));
    applyStimulus(1, 0, 0, 2'b00, 6'd4, 0, 6'd0, '0);
    quiet();
    @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    checkOutput("rst_async", {out_valid, busy, done, pc, out_obs}, '0);
    checkOutput("rst_data", out_data, 0);
    @(posedge clk); #2 rst = 1'b0;
    applyStimulus(1, 0, 0, 2'b00, 6'd4, 0, 6'd0, '0);
    quiet();
    waitDone("rst_replay_timeout", 20);
    checkOutput("rst_replay", out_data, 20);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
